imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered, parametrised immediate-generation stage for the five-stage RISC-V pipeline. It sits between fetch and the ID/EX register. It decodes the instruction format from the opcode and sign-extends the immediate to XLEN bits. Results go through a 2-entry skid buffer with valid/ready handshakes on both sides, so back-pressure from EX never creates a combinational path to fetch.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush; drops all held entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept an instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts the entry
- out_imm  out  XLEN  generated immediate
- out_fmt  out  3  format code: I=0, S=1, B=2, U=3, J=4, Z=5, NONE=7
- out_illegal  out  1  unrecognised opcode, or instr[1:0] != 2'b11
- out_instr  out  32  registered copy of instr
- out_pc  out  XLEN  registered copy of pc

## Operation
- Decode is combinational on in_instr. Its result is captured on acceptance (in_valid && in_ready).
- Opcode mapping:
  - 0010011, 0000011, 1100111 -> I: sext(instr[31:20])
  - 0100011 -> S: sext({instr[31:25], instr[11:7]})
  - 1100011 -> B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - 0110111, 0010111 -> U: sext({instr[31:12], 12'b0}); for XLEN=64, bit 31 is replicated upward
  - 1101111 -> J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - 0110011 -> NONE, imm 0
  - 1110011 -> Z or NONE; see Configuration
  - any other opcode, or instr[1:0] != 2'b11 -> fmt NONE, imm 0, out_illegal=1
- Buffer structure: a main register drives the out_* ports; a skid register holds one extra entry.
- in_ready = !skid_valid. This is a registered signal with no combinational dependence on out_ready.
- Accepted input, by state:
  - main empty, or main draining this cycle with skid empty -> goes to main
  - main full and not draining -> goes to skid
- Drain: main drains when out_valid && out_ready. If skid holds an entry, it moves into main on that same edge.
- Stall stability: out_* hold constant while out_valid && !out_ready.
- Flush:
  - clears main_valid and skid_valid on the next edge
  - has priority over a simultaneous acceptance; that input is dropped
  - does not block the drain handshake, but entries are gone after the edge
- Reset, asynchronous:
  - out_valid=0, in_ready=1, skid empty
  - out_imm, out_pc, out_instr = 0; out_fmt=7; out_illegal=0
  - reset asserted mid-transfer discards all entries immediately

## Timing
- Latency: an instruction accepted at edge N appears on out_* after edge N; 1 cycle.
- Throughput: 1 instruction per cycle while out_ready=1.
- Holding out_ready=0 from an empty start: two instructions are accepted, then in_ready=0 after the second edge. in_ready returns to 1 the cycle after the skid entry moves into main.
- No entry is lost or duplicated under any in_valid/out_ready pattern.
- Ordering is strict FIFO.

## Configuration
- IMM_ZICSR_EN defined:
  - opcode 1110011 with funct3[2]=1 -> fmt Z, imm = zero-extended instr[19:15]
  - opcode 1110011 with funct3[2]=0 -> NONE, imm 0
- IMM_ZICSR_EN undefined: opcode 1110011 -> NONE, imm 0, out_illegal=0 in all cases.

## Test plan
- Single instructions, XLEN=32, out_ready=1:
  - 0xFFF00093 -> imm 0xFFFFFFFF, fmt I
  - 0x0230A0A3 -> imm 33, fmt S
  - 0x02208163 -> imm 34, fmt B
  - 0x123450B7 -> imm 0x12345000, fmt U
  - 0xFFDFF06F -> imm 0xFFFFFFFC, fmt J
  - each result appears one cycle after acceptance
- XLEN=64 sign extension: 0x800000B7 -> imm 0xFFFFFFFF80000000, fmt U.
- Back-pressure: stream 4 instructions with out_ready=0 for 3 cycles, then 1.
  - in_ready drops after the 2nd acceptance
  - all 4 emerge in order
  - out_* stay stable throughout the stall
- Flush: flush=1 with both entries full and in_valid=1 -> out_valid=0 and in_ready=1 next cycle; the input is not captured.
- Illegal and async reset:
  - 0x00000013 with bit1 cleared (0x00000011) -> out_illegal=1, fmt 7, imm 0
  - rst pulsed between clock edges mid-stream -> out_valid falls immediately
- CSR immediate, 0x3002D073:
  - with IMM_ZICSR_EN -> imm 5, fmt Z
  - without IMM_ZICSR_EN -> imm 0, fmt 7, out_illegal=0

Source files
------------

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: RISC-V immediate decode feeding a 2-entry skid buffer (main + skid register).
// Optional build macro IMM_ZICSR_EN enables the CSR-immediate (fmt Z) decode for opcode 1110011.
module imm_gen_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc
);

   localparam logic [2:0] FMT_I    = 3'd0;
   localparam logic [2:0] FMT_S    = 3'd1;
   localparam logic [2:0] FMT_B    = 3'd2;
   localparam logic [2:0] FMT_U    = 3'd3;
   localparam logic [2:0] FMT_J    = 3'd4;
   localparam logic [2:0] FMT_Z    = 3'd5;
   localparam logic [2:0] FMT_NONE = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
   } entry_t;

   localparam entry_t RST_ENTRY = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, instr: '0, pc: '0};

   function automatic entry_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
      entry_t                 e;
      logic signed [XLEN-1:0] imm;
      imm       = '0;
      e.fmt     = FMT_NONE;
      e.illegal = 1'b0;
      e.instr   = instr;
      e.pc      = pc;
      if (instr[1:0] != 2'b11) begin
         e.illegal = 1'b1;
      end else begin
         case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
               e.fmt = FMT_I;
               imm   = XLEN'($signed(instr[31:20]));
            end
            7'b0100011: begin
               e.fmt = FMT_S;
               imm   = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            7'b1100011: begin
               e.fmt = FMT_B;
               imm   = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
               e.fmt = FMT_U;
               imm   = XLEN'($signed({instr[31:12], 12'b0}));
            end
            7'b1101111: begin
               e.fmt = FMT_J;
               imm   = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            end
            7'b0110011: begin
               e.fmt = FMT_NONE;
            end
            7'b1110011: begin
`ifdef IMM_ZICSR_EN
               // funct3[2] selects the uimm forms (csrrwi/csrrsi/csrrci)
               if (instr[14]) begin
                  e.fmt = FMT_Z;
                  imm   = $signed(XLEN'(instr[19:15]));
               end
`else
               e.fmt = FMT_NONE;
`endif
            end
            default: begin
               e.illegal = 1'b1;
            end
         endcase
      end
      e.imm = imm;
      return e;
   endfunction

   entry_t dec_p0;
   entry_t main_p1;
   entry_t skid_p1;
   logic   vld_p1;
   logic   skid_vld_p1;
   logic   accept;
   logic   drain;

   always_comb dec_p0 = decode(in_instr, in_pc);

   assign in_ready = !skid_vld_p1;
   assign accept   = in_valid && !skid_vld_p1;
   assign drain    = vld_p1 && out_ready;

   // p0 -> p1: main register feeds the outputs, skid catches one entry while main is stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         main_p1     <= RST_ENTRY;
         skid_p1     <= RST_ENTRY;
      end else if (flush) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
      end else if (!vld_p1) begin
         if (accept) begin
            main_p1 <= dec_p0;
            vld_p1  <= 1'b1;
         end
      end else if (drain) begin
         if (skid_vld_p1) begin
            main_p1     <= skid_p1;
            skid_vld_p1 <= 1'b0;
         end else if (accept) begin
            main_p1 <= dec_p0;
         end else begin
            vld_p1 <= 1'b0;
         end
      end else if (accept) begin
         skid_p1     <= dec_p0;
         skid_vld_p1 <= 1'b1;
      end
   end

   assign out_valid   = vld_p1;
   assign out_imm     = main_p1.imm;
   assign out_fmt     = main_p1.fmt;
   assign out_illegal = main_p1.illegal;
   assign out_instr   = main_p1.instr;
   assign out_pc      = main_p1.pc;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances on shared stimulus, checked against a FIFO reference model.
`timescale 1ns/1ps
module tb_imm_gen_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_instr;
   logic [63:0] pc64;

   logic        in_ready32, out_valid32, ill32;
   logic [31:0] imm32, pco32, instro32;
   logic [2:0]  fmt32;
   logic        in_ready64, out_valid64, ill64;
   logic [63:0] imm64, pco64;
   logic [31:0] instro64;
   logic [2:0]  fmt64;

   imm_gen_stage #(.XLEN(32)) dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_pc(pc64[31:0]),
      .out_valid(out_valid32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
      .out_illegal(ill32), .out_instr(instro32), .out_pc(pco32)
   );

   imm_gen_stage #(.XLEN(64)) dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(pc64),
      .out_valid(out_valid64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
      .out_illegal(ill64), .out_instr(instro64), .out_pc(pco64)
   );

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } ent_t;

   ent_t q[$];
   int   ntests = 0;
   int   nfail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic longint sx(input longint raw, input int bits);
      longint half;
      half = longint'(1) << (bits - 1);
      return (raw >= half) ? raw - 2 * half : raw;
   endfunction

   // Immediate values computed arithmetically from the field layout of each format
   function automatic void ref_decode(input logic [31:0] i, output longint v, output int fmt, output bit ill);
      longint raw;
      v = 0; fmt = 7; ill = 1'b0;
      if (i[1:0] != 2'b11) begin
         ill = 1'b1;
         return;
      end
      case (i[6:0])
         7'h13, 7'h03, 7'h67: begin
            fmt = 0; raw = longint'(i[31:20]); v = sx(raw, 12);
         end
         7'h23: begin
            fmt = 1; raw = longint'(i[31:25]) * 32 + longint'(i[11:7]); v = sx(raw, 12);
         end
         7'h63: begin
            fmt = 2;
            raw = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            v = sx(raw, 13);
         end
         7'h37, 7'h17: begin
            fmt = 3; raw = longint'(i[31:12]) * 4096; v = sx(raw, 32);
         end
         7'h6F: begin
            fmt = 4;
            raw = longint'(i[31]) * (longint'(1) << 20) + longint'(i[19:12]) * 4096 +
                  longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            v = sx(raw, 21);
         end
         7'h33: fmt = 7;
         7'h73: begin
`ifdef IMM_ZICSR_EN
            if (i[14]) begin
               fmt = 5; v = longint'(i[19:15]);
            end
`endif
         end
         default: ill = 1'b1;
      endcase
   endfunction

   task automatic step(input bit v, input logic [31:0] instr, input bit ordy, input bit fl, output bit acc);
      longint imm;
      int     fmt;
      bit     ill;
      ent_t   e;
      in_valid  = v;
      in_instr  = instr;
      out_ready = ordy;
      flush     = fl;
      pc64      = {$urandom, $urandom} & ~64'h3;
      check("in_ready32", in_ready32, q.size() < 2);
      check("out_valid32", out_valid32, q.size() > 0);
      check("in_ready64", in_ready64, q.size() < 2);
      check("out_valid64", out_valid64, q.size() > 0);
      if (q.size() > 0) begin
         ref_decode(q[0].instr, imm, fmt, ill);
         check("imm32", imm32, imm[31:0]);
         check("fmt32", fmt32, fmt);
         check("illegal32", ill32, ill);
         check("instr32", instro32, q[0].instr);
         check("pc32", pco32, q[0].pc[31:0]);
         check("imm64", imm64, imm);
         check("fmt64", fmt64, fmt);
         check("illegal64", ill64, ill);
         check("instr64", instro64, q[0].instr);
         check("pc64", pco64, q[0].pc);
      end
      e.instr = instr;
      e.pc    = pc64;
      acc     = v && (q.size() < 2) && !fl;
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         if (q.size() > 0 && ordy) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      #1;
   endtask

   logic [31:0] singles [9] = '{32'hFFF00093, 32'h0230A0A3, 32'h02208163, 32'h123450B7, 32'hFFDFF06F,
                                32'h800000B7, 32'h00000011, 32'h3002D073, 32'h00000033};
   logic [31:0] bp_instr [4] = '{32'h00500093, 32'h0230A0A3, 32'hFFDFF06F, 32'h02208163};
   logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h0B, 7'h11};

   initial begin
      bit acc;
      int idx;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; pc64 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid32", out_valid32, 0);
      check("rst_in_ready32", in_ready32, 1);
      check("rst_imm32", imm32, 0);
      check("rst_fmt32", fmt32, 7);
      check("rst_illegal32", ill32, 0);
      check("rst_instr32", instro32, 0);
      check("rst_pc32", pco32, 0);
      check("rst_out_valid64", out_valid64, 0);
      check("rst_imm64", imm64, 0);
      check("rst_fmt64", fmt64, 7);
      rst = 1'b0;

      // Directed single instructions, one idle cycle after each
      for (int k = 0; k < 9; k++) begin
         step(1'b1, singles[k], 1'b1, 1'b0, acc);
         step(1'b0, 32'h0, 1'b1, 1'b0, acc);
      end

      // Back-pressure: out_ready low for three cycles, upstream holds until accepted
      idx = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc == 2) check("bp_in_ready_low", in_ready32, 0);
         step(idx < 4, bp_instr[idx % 4], cyc >= 3, 1'b0, acc);
         if (acc) idx++;
      end
      check("bp_all_accepted", idx, 4);

      // Flush with both entries full and a pending input
      step(1'b1, 32'h00100093, 1'b0, 1'b0, acc);
      step(1'b1, 32'h00200093, 1'b0, 1'b0, acc);
      step(1'b1, 32'h00300093, 1'b0, 1'b1, acc);
      check("flush_out_valid", out_valid32, 0);
      check("flush_in_ready", in_ready32, 1);
      // Flush with only main full: the simultaneous input is dropped
      step(1'b1, 32'h00400093, 1'b0, 1'b0, acc);
      step(1'b1, 32'h00500093, 1'b1, 1'b1, acc);
      step(1'b0, 32'h0, 1'b1, 1'b0, acc);

      // Asynchronous reset between edges, mid-stream
      step(1'b1, 32'h00600093, 1'b0, 1'b0, acc);
      step(1'b1, 32'h00700093, 1'b0, 1'b0, acc);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid32", out_valid32, 0);
      check("arst_in_ready32", in_ready32, 1);
      check("arst_out_valid64", out_valid64, 0);
      check("arst_fmt32", fmt32, 7);
      q.delete();
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         logic [31:0] r;
         r = $urandom;
         step($urandom_range(0, 3) != 0, {r[31:7], ops[$urandom_range(0, 11)]},
              $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0, acc);
      end
      step(1'b0, 32'h0, 1'b1, 1'b0, acc);
      step(1'b0, 32'h0, 1'b1, 1'b0, acc);
      step(1'b0, 32'h0, 1'b1, 1'b0, acc);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
